bt_uart_rx: RTL and testbench

Receive path for the Bluetooth UART link. It sits between the `BT_RX` pad and the `SECURE_PLATFORM_RI5CY` peripheral bus. It synchronises and oversamples the serial line, deframes 8N1 characters and buffers them in a small FIFO with a valid/ready output. It drives RTS flow control toward the Bluetooth module and a level interrupt toward the core.

---
 rtl/bt_uart_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_bt_uart_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_uart_rx.sv
// bt_uart_rx - receive path for the Bluetooth UART link.
//
// The raw BT_RX pad is synchronised and oversampled, and 8N1 characters are
// deframed and buffered in a small show-ahead FIFO. The FIFO is presented on a
// valid/ready interface. The block also drives RTS flow control toward the
// module and a level interrupt toward the core.
//
// Parameters:
//   CLKS_PER_BIT  : clock cycles per bit (>= 8)
//   FIFO_DEPTH    : FIFO entries (power of two, >= 2)
//   RTS_THRESHOLD : occupancy at which rts_n goes high (1 .. FIFO_DEPTH)
//
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   rx_in         : asynchronous serial input, idles high
//   rx_data       : FIFO head byte (0x00 while empty)
//   rx_valid      : FIFO non-empty
//   rx_ready      : consumer pops the head when rx_valid & rx_ready
//   rts_n         : 1 = ask the sender to stop
//   rx_irq        : level interrupt, same as rx_valid
//   frame_err     : one-cycle pulse on a bad stop bit
//   overrun       : one-cycle pulse when a good byte is dropped on a full FIFO
//   fifo_count    : current occupancy
module bt_uart_rx #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int FIFO_DEPTH    = 8,
  parameter int RTS_THRESHOLD = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_in,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rts_n,
  output logic                          rx_irq,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2 - 1;
  localparam int LAST = CLKS_PER_BIT - 1;

  // ---------------------------------------------------------------
  // Input synchroniser and falling-edge detector. Flops reset to the
  // idle level so a reset never manufactures a start edge.
  // ---------------------------------------------------------------
  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic rx_s;
  logic fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rx_s = sync2_reg;
  assign fall = prev_reg & ~rx_s;

  // ---------------------------------------------------------------
  // Deframer FSM
  // ---------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   tick_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            frame_err_reg;
  logic            push_stb;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      tick_reg      <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (fall) begin
            state_reg <= S_START;
            tick_reg  <= '0;
          end
        end
        S_START: begin
          // Re-check the line at mid start bit; a high here was a glitch.
          if (tick_reg == TW'(HALF)) begin
            tick_reg <= '0;
            if (!rx_s) begin
              state_reg   <= S_DATA;
              bit_cnt_reg <= '0;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_reg == TW'(LAST)) begin
            tick_reg  <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= S_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_reg == TW'(LAST)) begin
            tick_reg <= '0;
            if (rx_s) begin
              state_reg <= S_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= S_WAIT_IDLE;
            end
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        S_WAIT_IDLE: begin
          // A held-low line (break) reports one error, then waits here.
          if (rx_s) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The byte is written on the very edge that samples a good stop bit.
  assign push_stb = (state_reg == S_STOP) && (tick_reg == TW'(LAST)) && rx_s;

  // ---------------------------------------------------------------
  // Show-ahead FIFO. The head byte is held in a register that is
  // reloaded from the array (or bypassed from the incoming byte) so the
  // array itself only sees registered reads.
  // ---------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [7:0]    head_reg;
  logic          overrun_reg;
  logic          rts_n_reg;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign pop     = rx_valid & rx_ready;
  assign push_ok = push_stb & (~full | pop);

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      head_reg    <= 8'h00;
      overrun_reg <= 1'b0;
      rts_n_reg   <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= push_stb & full & ~pop;
      rts_n_reg   <= (count_reg >= CW'(RTS_THRESHOLD));
      // New head: empty -> 0; the slot being written this cycle -> bypass;
      // otherwise the stored entry at the next read pointer.
      if (count_next == '0) begin
        head_reg <= 8'h00;
      end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= shift_reg;
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign rx_valid   = (count_reg != '0);
  assign rx_irq     = rx_valid;
  assign rx_data    = head_reg;
  assign fifo_count = count_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign rts_n      = rts_n_reg;

endmodule

// File: tb/tb_bt_uart_rx.sv
// Testbench for bt_uart_rx with CLKS_PER_BIT=16, FIFO_DEPTH=8, RTS_THRESHOLD=6.
// Expected bytes go into a scoreboard queue when a frame is sent; a monitor
// pops and compares on every valid/ready handshake.
module tb_bt_uart_rx;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rts_n;
  logic       rx_irq;
  logic       frame_err;
  logic       overrun;
  logic [3:0] fifo_count;

  bt_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .RTS_THRESHOLD(6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rts_n     (rts_n),
    .rx_irq    (rx_irq),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fifo_count(fifo_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [7:0] sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int f0;
  int o0;
  logic [3:0] prev_cnt   = '0;
  logic       prev_run   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected byte.
  always @(negedge clock) begin
    if (!reset && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        automatic logic [7:0] e = sb.pop_front();
        $display("pop data=0x%02h expected=0x%02h", rx_data, e);
        check("pop_data", 32'(rx_data), 32'(e));
      end
    end
  end

  // Pulse counters and the one-cycle RTS lag relation.
  always @(negedge clock) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (!reset && prev_run)
      check("rts_lag", 32'(rts_n), 32'(prev_cnt >= 4'd6));
    prev_cnt <= fifo_count;
    prev_run <= !reset;
  end

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (CPB) @(posedge clock);
    #2;
  endtask

  // Sends one 8N1 frame; the line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clock);
    #2;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    $display("sent byte=0x%02h stop=%0d", b, stop);
  endtask

  task automatic drain(input int n);
    @(posedge clock);
    #2 rx_ready = 1'b1;
    repeat (n) @(posedge clock);
    #2 rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_irq"},   32'(rx_irq), 32'd0);
    check({tag, "_data"},  32'(rx_data), 32'h00);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_ovr"},   32'(overrun), 32'd0);
    check({tag, "_rts"},   32'(rts_n), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;

    // Reset values, then rts_n falls on the first clock after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("reset");
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rts_after_reset", 32'(rts_n), 32'd0);
    idle(5);

    // Single good byte.
    f0 = ferr_cnt; o0 = ovr_cnt;
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(2);
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_data",  32'(rx_data), 32'hA5);
    check("a5_count", 32'(fifo_count), 32'd1);
    check("a5_irq",   32'(rx_irq), 32'd1);
    check("a5_ferr",  32'(ferr_cnt - f0), 32'd0);
    check("a5_ovr",   32'(ovr_cnt - o0), 32'd0);
    drain(1);
    idle(2);
    check("a5_drained", 32'(fifo_count), 32'd0);

    // Start-bit glitch.
    f0 = ferr_cnt;
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(30);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt - f0), 32'd0);

    // Bad stop bit followed by a held-low line: one frame error only.
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    idle(40);
    rx_in = 1'b1;
    idle(20);
    check("break_ferr",  32'(ferr_cnt - f0), 32'd1);
    check("break_count", 32'(fifo_count), 32'd0);
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(2);
    check("after_break_data",  32'(rx_data), 32'h55);
    check("after_break_count", 32'(fifo_count), 32'd1);
    drain(1);
    idle(3);

    // Nine bytes into an eight-entry FIFO.
    o0 = ovr_cnt;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    idle(2);
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_pulse", 32'(ovr_cnt - o0), 32'd1);
    check("ovf_rts",   32'(rts_n), 32'd1);
    check("ovf_head",  32'(rx_data), 32'h01);
    drain(8);
    idle(3);
    check("ovf_drained", 32'(fifo_count), 32'd0);
    check("ovf_rts_low", 32'(rts_n), 32'd0);

    // Full FIFO with a pop on the same edge as the push of 0x77.
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'h11 + 8'(i));
      send_byte(8'h11 + 8'(i), 1'b1);
    end
    idle(2);
    check("full_count", 32'(fifo_count), 32'd8);
    o0 = ovr_cnt;
    sb.push_back(8'h77);
    fork
      send_byte(8'h77, 1'b1);
      begin
        // Push lands 155 clocks after the edge that launches the start bit.
        @(posedge clock);
        repeat (154) @(posedge clock);
        #2 rx_ready = 1'b1;
        @(posedge clock);
        #2 rx_ready = 1'b0;
      end
    join
    idle(2);
    check("pushpop_ovr",   32'(ovr_cnt - o0), 32'd0);
    check("pushpop_count", 32'(fifo_count), 32'd8);
    drain(8);
    idle(3);
    check("pushpop_drained", 32'(fifo_count), 32'd0);

    // Reset in the middle of a frame with three bytes buffered.
    for (int i = 0; i < 3; i++) send_byte(8'hA1 + 8'(i), 1'b1);
    idle(2);
    check("pre_reset_count", 32'(fifo_count), 32'd3);
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_in = 1'b0;
    idle(CPB + 40);
    reset = 1'b1;
    rx_in = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_vals("midframe_reset");
    @(posedge clock);
    #2 reset = 1'b0;
    idle(40);
    check("midframe_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("midframe_ovr",  32'(ovr_cnt - o0), 32'd0);
    check("midframe_count", 32'(fifo_count), 32'd0);
    sb.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(2);
    check("c3_count", 32'(fifo_count), 32'd1);
    check("c3_data",  32'(rx_data), 32'hC3);
    drain(1);
    idle(3);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
